bus_cmd_receiver: RTL and testbench

- Downstream consumer of the shared command byte bus driven by the AES/SHA bus arbiter.
- Accepts bytes under a valid/ready handshake and reassembles each (ADDRW+8)-bit command word, least-significant byte first.
- Decodes the word into op/source/address and buffers complete commands in a small FIFO for the memory-side datapath.
- Flags illegal opcodes and stalled partial words.

---
 rtl/bus_cmd_receiver.sv | 160 ++++++++++++++++
 tb/tb_bus_cmd_receiver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_cmd_receiver.sv
// bus_cmd_receiver
//   Byte-stream command reassembler. It sits downstream of the AES/SHA bus
//   arbiter. Bytes arrive least-significant first under a valid/ready
//   handshake. Each completed (ADDRW+8)-bit word is decoded into
//   op/src/addr and queued in a small FIFO for the memory-side datapath.
//   Words with op=11 are dropped and flagged. Partial words that stall
//   for TIMEOUT idle cycles are discarded and flagged.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   valid_in     byte valid from arbiter
//   data_in      byte from arbiter
//   ready_out    byte accepted when valid_in && ready_out
//   cmd_valid    FIFO head valid
//   cmd_ready    consumer pops head when cmd_valid && cmd_ready
//   cmd_op       head opcode (00 read, 01 write, 10 hash-load)
//   cmd_src      head source (0 AES, 1 SHA)
//   cmd_addr     head address
//   err_illegal  one-cycle pulse: op=11 word completed and dropped
//   err_timeout  one-cycle pulse: partial word aborted
//   fifo_level   current FIFO occupancy
module bus_cmd_receiver #(
  parameter int ADDRW   = 24,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [7:0]                 data_in,
  output logic                       ready_out,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [1:0]                 cmd_op,
  output logic                       cmd_src,
  output logic [ADDRW-1:0]           cmd_addr,
  output logic                       err_illegal,
  output logic                       err_timeout,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int NB = (ADDRW + 8) / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = ADDRW + 3;

  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [7:0]    IDLE_LOAD = 8'(TIMEOUT);

  logic [CW-1:0]    byte_cnt;
  logic [7:0]       idle_left;
  logic [ADDRW-1:0] addr_sr;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic xfer;
  logic word_done;
  logic illegal;
  logic push;
  logic pop;
  logic unused_hdr;

  // Header bits [6:2] carry nothing for this consumer.
  assign unused_hdr = ^data_in[6:2];

  // Only the header byte can be refused. Earlier bytes of a word are
  // always taken, even when the FIFO is full. This keeps ready_out
  // independent of cmd_ready.
  assign ready_out = (byte_cnt != LAST_BYTE) || (fifo_level != FULL_LVL);
  assign xfer      = valid_in && ready_out;
  assign word_done = xfer && (byte_cnt == LAST_BYTE);
  assign illegal   = word_done && (data_in[1:0] == 2'b11);
  assign push      = word_done && !illegal;
  assign cmd_valid = (fifo_level != '0);
  assign pop       = cmd_valid && cmd_ready;

  assign {cmd_src, cmd_op, cmd_addr} = mem[rd_ptr];

  // Byte counter and idle timer.
  // idle_left counts down from TIMEOUT on each idle cycle mid-word. An
  // idle edge that sees a count of 1 is the TIMEOUT-th idle cycle, so
  // the word is aborted on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      idle_left   <= IDLE_LOAD;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (xfer) begin
        idle_left <= IDLE_LOAD;
        byte_cnt  <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
      end else if ((byte_cnt != '0) && !valid_in) begin
        if (idle_left == 8'd1) begin
          byte_cnt    <= '0;
          idle_left   <= IDLE_LOAD;
          err_timeout <= 1'b1;
        end else begin
          idle_left <= idle_left - 8'd1;
        end
      end else if (byte_cnt == '0) begin
        idle_left <= IDLE_LOAD;
      end
    end
  end

  // Address bytes are collected here. The header byte goes straight
  // into the FIFO entry on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sr <= '0;
    end else begin
      for (int k = 0; k < NB - 1; k++) begin
        if (xfer && (byte_cnt == CW'(k))) begin
          addr_sr[8*k +: 8] <= data_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= illegal;
    end
  end

  // Command FIFO. The storage is reset so that the head fields read 0
  // out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {data_in[7], data_in[1:0], addr_sr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cmd_receiver.sv
module tb_bus_cmd_receiver;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ready_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_src;
  logic [23:0] cmd_addr;
  logic        err_illegal;
  logic        err_timeout;
  logic [1:0]  fifo_level;

  int n_vec = 0;
  int n_bad = 0;
  logic seen_to;

  bus_cmd_receiver #(.ADDRW(24), .DEPTH(2), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_out   (ready_out),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_src     (cmd_src),
    .cmd_addr    (cmd_addr),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = b;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic check_head(input string tag, input logic [1:0] op, input logic src,
                            input logic [23:0] addr);
    check_val({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
    check_val({tag, "_op"},    {30'd0, cmd_op},    {30'd0, op});
    check_val({tag, "_src"},   {31'd0, cmd_src},   {31'd0, src});
    check_val({tag, "_addr"},  {8'd0, cmd_addr},   {8'd0, addr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    data_in   = 8'h00;
    cmd_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("rst_ready",   {31'd0, ready_out},   32'd1);
    check_val("rst_cvalid",  {31'd0, cmd_valid},   32'd0);
    check_val("rst_op",      {30'd0, cmd_op},      32'd0);
    check_val("rst_src",     {31'd0, cmd_src},     32'd0);
    check_val("rst_addr",    {8'd0, cmd_addr},     32'd0);
    check_val("rst_eill",    {31'd0, err_illegal}, 32'd0);
    check_val("rst_eto",     {31'd0, err_timeout}, 32'd0);
    check_val("rst_level",   {30'd0, fifo_level},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, write from SHA to 0xAB1234
    cmd_ready = 1'b1;
    send(8'h34); send(8'h12); send(8'hAB); send(8'h81);
    idle_cyc();
    check_head("single", 2'b01, 1'b1, 24'hAB1234);
    check_val("single_level", {30'd0, fifo_level}, 32'd1);
    idle_cyc();
    check_val("single_pop_valid", {31'd0, cmd_valid}, 32'd0);
    check_val("single_pop_level", {30'd0, fifo_level}, 32'd0);

    // Backpressure: three words into a two-deep FIFO
    cmd_ready = 1'b0;
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h02); send(8'h00); send(8'h00); send(8'h81);
    idle_cyc();
    check_val("bp_level2", {30'd0, fifo_level}, 32'd2);
    check_head("bp_head1", 2'b00, 1'b0, 24'h000001);
    send(8'h03);
    check_val("bp_rdy_b0", {31'd0, ready_out}, 32'd1);
    send(8'h03);
    send(8'h03);
    check_val("bp_rdy_b2", {31'd0, ready_out}, 32'd1);
    send(8'h02);
    check_val("bp_rdy_b3", {31'd0, ready_out}, 32'd0);
    @(negedge clk);
    check_val("bp_rdy_hold", {31'd0, ready_out}, 32'd0);
    check_val("bp_level_hold", {30'd0, fifo_level}, 32'd2);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check_val("bp_level_pop", {30'd0, fifo_level}, 32'd1);
    check_val("bp_rdy_after", {31'd0, ready_out}, 32'd1);
    check_head("bp_head2", 2'b01, 1'b1, 24'h000002);
    idle_cyc();
    check_val("bp_level_w3", {30'd0, fifo_level}, 32'd2);
    check_head("bp_head2_stable", 2'b01, 1'b1, 24'h000002);
    cmd_ready = 1'b1;
    @(negedge clk);
    check_head("bp_head3", 2'b10, 1'b0, 24'h030303);
    check_val("bp_level_last", {30'd0, fifo_level}, 32'd1);
    @(negedge clk);
    check_val("bp_empty", {31'd0, cmd_valid}, 32'd0);
    check_val("bp_empty_lvl", {30'd0, fifo_level}, 32'd0);

    // Illegal opcode is dropped
    send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    idle_cyc();
    check_val("ill_pulse", {31'd0, err_illegal}, 32'd1);
    check_val("ill_cvalid", {31'd0, cmd_valid}, 32'd0);
    check_val("ill_level", {30'd0, fifo_level}, 32'd0);
    idle_cyc();
    check_val("ill_pulse_end", {31'd0, err_illegal}, 32'd0);
    send(8'h55); send(8'h66); send(8'h77); send(8'h02);
    idle_cyc();
    check_head("ill_next", 2'b10, 1'b0, 24'h776655);
    idle_cyc();

    // Timeout after 15 idle cycles mid-word
    send(8'hAA); send(8'hBB);
    for (int i = 0; i < 14; i++) idle_cyc();
    idle_cyc();
    check_val("to_not_yet", {31'd0, err_timeout}, 32'd0);
    idle_cyc();
    check_val("to_pulse", {31'd0, err_timeout}, 32'd1);
    send(8'h00);
    check_val("to_pulse_end", {31'd0, err_timeout}, 32'd0);
    send(8'h00); send(8'h10); send(8'h00);
    idle_cyc();
    check_head("to_next", 2'b00, 1'b0, 24'h100000);
    idle_cyc();

    // 14 idle cycles mid-word does not time out
    seen_to = 1'b0;
    send(8'h01); send(8'h02);
    for (int i = 0; i < 14; i++) begin
      idle_cyc();
      seen_to = seen_to | err_timeout;
    end
    send(8'h03); seen_to = seen_to | err_timeout;
    send(8'h84); seen_to = seen_to | err_timeout;
    idle_cyc();  seen_to = seen_to | err_timeout;
    check_val("stall_no_to", {31'd0, seen_to}, 32'd0);
    check_head("stall_word", 2'b00, 1'b1, 24'h030201);
    idle_cyc();

    // Reset mid-word with one entry queued
    cmd_ready = 1'b0;
    send(8'h04); send(8'h05); send(8'h06); send(8'h01);
    idle_cyc();
    check_val("mrst_level_pre", {30'd0, fifo_level}, 32'd1);
    send(8'h99);
    idle_cyc();
    rst_n = 1'b0;
    #1;
    check_val("mrst_cvalid", {31'd0, cmd_valid},   32'd0);
    check_val("mrst_level",  {30'd0, fifo_level},  32'd0);
    check_val("mrst_op",     {30'd0, cmd_op},      32'd0);
    check_val("mrst_src",    {31'd0, cmd_src},     32'd0);
    check_val("mrst_addr",   {8'd0, cmd_addr},     32'd0);
    check_val("mrst_eill",   {31'd0, err_illegal}, 32'd0);
    check_val("mrst_eto",    {31'd0, err_timeout}, 32'd0);
    check_val("mrst_ready",  {31'd0, ready_out},   32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    send(8'h78); send(8'h56); send(8'h34); send(8'hC2);
    idle_cyc();
    check_head("mrst_next", 2'b10, 1'b1, 24'h345678);
    check_val("mrst_next_lvl", {30'd0, fifo_level}, 32'd1);
    idle_cyc();
    check_val("mrst_final_lvl", {30'd0, fifo_level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
